axi_stream_n_to_1_arbiter: RTL and testbench

- Merges NUM_INPUTS AXI Stream inputs onto one AXI Stream output. It is the converging counterpart of the tdest-routed 1-to-N switch; the pair sits between virtualized tenant regions and a shared egress stream.
- Arbitration is round-robin and per packet: a grant is held from the first beat through the accepted tlast beat.
- The output has one register stage, so latency is 1 cycle.
- Optionally overwrites tid with the source input index so the downstream 1-to-N switch can route responses back.

---
 rtl/axis_arb_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/axi_stream_n_to_1_arbiter.sv | 84 ++++++++
 tb/tb_axi_stream_n_to_1_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared arbiter state type and index-width helper for the AXI Stream N-to-1 arbiter
package axis_arb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first req at or above ptr (mod N); ports req, ptr -> gnt_onehot, gnt_idx, any
module rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx,
  output logic         any
);
  logic [W-1:0] idx;
  always_comb begin
    idx = '0;
    gnt_idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(ptr) + i) % N);
      if (req[idx]) gnt_idx = idx;
    end
    gnt_onehot = any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/axi_stream_n_to_1_arbiter.sv
// axi_stream_n_to_1_arbiter: packet-locked round-robin merge of NUM_INPUTS packed AXI Stream inputs (axis_in_*) onto one registered output (axis_out_*), aclk/aresetn
module axi_stream_n_to_1_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_INPUTS       = 4,
  parameter int AXIS_BUS_WIDTH   = 64,
  parameter int AXIS_TID_WIDTH   = 5,
  parameter int AXIS_TDEST_WIDTH = 1,
  parameter int AXIS_TUSER_WIDTH = 1,
  parameter int TID_INSERT       = 1
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic [NUM_INPUTS*AXIS_BUS_WIDTH-1:0]     axis_in_tdata,
  input  logic [NUM_INPUTS*AXIS_BUS_WIDTH/8-1:0]   axis_in_tkeep,
  input  logic [NUM_INPUTS*AXIS_TID_WIDTH-1:0]     axis_in_tid,
  input  logic [NUM_INPUTS*AXIS_TDEST_WIDTH-1:0]   axis_in_tdest,
  input  logic [NUM_INPUTS*AXIS_TUSER_WIDTH-1:0]   axis_in_tuser,
  input  logic [NUM_INPUTS-1:0]                    axis_in_tlast,
  input  logic [NUM_INPUTS-1:0]                    axis_in_tvalid,
  output logic [NUM_INPUTS-1:0]                    axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]                axis_out_tdata,
  output logic [AXIS_BUS_WIDTH/8-1:0]              axis_out_tkeep,
  output logic [AXIS_TID_WIDTH-1:0]                axis_out_tid,
  output logic [AXIS_TDEST_WIDTH-1:0]              axis_out_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0]              axis_out_tuser,
  output logic                                     axis_out_tlast,
  output logic                                     axis_out_tvalid,
  input  logic                                     axis_out_tready
);
  localparam int N  = NUM_INPUTS;
  localparam int DW = AXIS_BUS_WIDTH;
  localparam int KW = DW / 8;
  localparam int IW = AXIS_TID_WIDTH;
  localparam int TW = AXIS_TDEST_WIDTH;
  localparam int UW = AXIS_TUSER_WIDTH;
  localparam int W  = clog2_min1(N);
  arb_state_t state;
  logic [W-1:0] rr_ptr, grant, arb_idx, src, rr_next;
  logic [N-1:0] arb_onehot;
  logic arb_any, accept, hs, src_last;
  rr_arbiter #(.N(N)) u_rr (
    .req(axis_in_tvalid),
    .ptr(rr_ptr),
    .gnt_onehot(arb_onehot),
    .gnt_idx(arb_idx),
    .any(arb_any)
  );
  always_comb begin
    accept = !axis_out_tvalid || axis_out_tready;
    src = state == IDLE ? arb_idx : grant;
    hs = accept && (state == IDLE ? arb_any : axis_in_tvalid[src]);
    axis_in_tready = {N{accept}} & (state == IDLE ? arb_onehot : N'(1) << grant);
    src_last = axis_in_tlast[src];
    rr_next = int'(src) == N - 1 ? '0 : src + 1'b1;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      axis_out_tvalid <= 1'b0;
      axis_out_tdata <= '0;
      axis_out_tkeep <= '0;
      axis_out_tid <= '0;
      axis_out_tdest <= '0;
      axis_out_tuser <= '0;
      axis_out_tlast <= 1'b0;
    end else begin
      if (accept) axis_out_tvalid <= hs;
      if (hs) begin
        axis_out_tdata <= axis_in_tdata[int'(src)*DW +: DW];
        axis_out_tkeep <= axis_in_tkeep[int'(src)*KW +: KW];
        axis_out_tid <= TID_INSERT != 0 ? IW'(src) : axis_in_tid[int'(src)*IW +: IW];
        axis_out_tdest <= axis_in_tdest[int'(src)*TW +: TW];
        axis_out_tuser <= axis_in_tuser[int'(src)*UW +: UW];
        axis_out_tlast <= src_last;
        grant <= src;
        state <= src_last ? IDLE : LOCKED;
        if (state == IDLE) rr_ptr <= rr_next;
      end
    end
  end
endmodule

// File: tb/tb_axi_stream_n_to_1_arbiter.sv
// tb_axi_stream_n_to_1_arbiter: directed self-checking bench for the 4-input AXI Stream arbiter
module tb_axi_stream_n_to_1_arbiter;
  logic aclk, aresetn, out_tready;
  logic [255:0] in_tdata;
  logic [31:0] in_tkeep;
  logic [19:0] in_tid;
  logic [3:0] in_tdest, in_tuser, in_tlast, in_tvalid, in_tready, hold;
  logic [63:0] out_tdata;
  logic [7:0] out_tkeep;
  logic [4:0] out_tid;
  logic [0:0] out_tdest, out_tuser;
  logic out_tlast, out_tvalid;
  int sent[4] = '{0, 0, 0, 0};
  int total[4] = '{0, 0, 0, 0};
  int base[4] = '{0, 0, 0, 0};
  int plen[4] = '{1, 1, 1, 1};
  logic [7:0] d0[4];
  logic [15:0] mon_q[$];
  logic [15:0] exp_q[$];
  int mon_base = 0;
  int tests = 0;
  int fails = 0;
  axi_stream_n_to_1_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tdata(in_tdata), .axis_in_tkeep(in_tkeep), .axis_in_tid(in_tid),
    .axis_in_tdest(in_tdest), .axis_in_tuser(in_tuser), .axis_in_tlast(in_tlast),
    .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready),
    .axis_out_tdata(out_tdata), .axis_out_tkeep(out_tkeep), .axis_out_tid(out_tid),
    .axis_out_tdest(out_tdest), .axis_out_tuser(out_tuser), .axis_out_tlast(out_tlast),
    .axis_out_tvalid(out_tvalid), .axis_out_tready(out_tready)
  );
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  assign in_tkeep = '1;
  assign in_tid = '1;
  assign in_tdest = '0;
  assign in_tuser = '0;
  always_comb begin
    in_tdata = '0;
    in_tlast = '0;
    in_tvalid = '0;
    for (int i = 0; i < 4; i++) begin
      in_tvalid[i] = !hold[i] && sent[i] < total[i];
      in_tdata[i*64 +: 64] = 64'(d0[i] + 8'(sent[i] - base[i]));
      in_tlast[i] = ((sent[i] - base[i]) % plen[i]) == plen[i] - 1;
    end
  end
  always @(posedge aclk)
    if (aresetn)
      for (int i = 0; i < 4; i++)
        if (in_tvalid[i] && in_tready[i]) sent[i] <= sent[i] + 1;
  always @(posedge aclk)
    if (aresetn && out_tvalid && out_tready)
      mon_q.push_back({out_tlast, 2'b0, out_tid, out_tdata[7:0]});
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [15:0] mk(input logic [4:0] id, input logic [7:0] d, input logic l);
    return {l, 2'b0, id, d};
  endfunction
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic outchk(input string tag, input logic v, input logic [7:0] d, input logic [4:0] id, input logic l);
    chk(tag, {out_tvalid, out_tlast, out_tid, out_tdata}, {v, l, id, 56'b0, d});
  endtask
  task automatic check_q(input string tag);
    chk({tag, "_len"}, 80'(mon_q.size() - mon_base), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (mon_base + i < mon_q.size()) ? 80'(mon_q[mon_base + i]) : 80'hdead, 80'(exp_q[i]));
  endtask
  task automatic load(input int i, input int n, input int len, input logic [7:0] d);
    base[i] = sent[i];
    total[i] = sent[i] + n;
    plen[i] = len;
    d0[i] = d;
  endtask
  task automatic idle(input int i);
    total[i] = sent[i];
  endtask
  initial begin
    aresetn = 1'b0;
    out_tready = 1'b1;
    hold = '0;
    for (int i = 0; i < 4; i++) d0[i] = '0;
    #2;
    outchk("rst_out", 1'b0, 8'h00, 5'd0, 1'b0);
    chk("rst_rdy", in_tready, 4'b0000);
    tick();
    tick();
    aresetn = 1'b1;
    #1;
    chk("idle_rdy", in_tready, 4'b0000);
    tick();
    chk("idle_valid", out_tvalid, 1'b0);
    load(1, 3, 3, 8'h11);
    #1;
    chk("t1_rdy", in_tready, 4'b0010);
    tick();
    outchk("t1_b0", 1'b1, 8'h11, 5'd1, 1'b0);
    chk("t1_keep", out_tkeep, 8'hFF);
    tick();
    outchk("t1_b1", 1'b1, 8'h12, 5'd1, 1'b0);
    tick();
    outchk("t1_b2", 1'b1, 8'h13, 5'd1, 1'b1);
    chk("t1_rdy_done", in_tready, 4'b0000);
    tick();
    chk("t1_drain", out_tvalid, 1'b0);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    mon_base = mon_q.size();
    load(0, 4, 2, 8'h01);
    load(2, 4, 2, 8'h21);
    repeat (9) tick();
    exp_q = {mk(0, 8'h01, 0), mk(0, 8'h02, 1), mk(2, 8'h21, 0), mk(2, 8'h22, 1),
             mk(0, 8'h03, 0), mk(0, 8'h04, 1), mk(2, 8'h23, 0), mk(2, 8'h24, 1)};
    check_q("t2");
    mon_base = mon_q.size();
    load(3, 3, 3, 8'h31);
    #1;
    chk("t3_rdy", in_tready, 4'b1000);
    tick();
    load(0, 1, 1, 8'h0A);
    hold[3] = 1'b1;
    #1;
    chk("t3_lock_stall", in_tready, 4'b1000);
    tick();
    chk("t3_bubble", out_tvalid, 1'b0);
    chk("t3_lock_hold", in_tready, 4'b1000);
    hold[3] = 1'b0;
    tick();
    tick();
    chk("t3_wrap_rdy", in_tready, 4'b0001);
    tick();
    tick();
    exp_q = {mk(3, 8'h31, 0), mk(3, 8'h32, 0), mk(3, 8'h33, 1), mk(0, 8'h0A, 1)};
    check_q("t3");
    mon_base = mon_q.size();
    load(1, 4, 4, 8'h41);
    tick();
    tick();
    out_tready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      tick();
      outchk($sformatf("t4_hold_%0d", k), 1'b1, 8'h42, 5'd1, 1'b0);
      chk($sformatf("t4_rdy_%0d", k), in_tready, 4'b0000);
    end
    out_tready = 1'b1;
    repeat (3) tick();
    exp_q = {mk(1, 8'h41, 0), mk(1, 8'h42, 0), mk(1, 8'h43, 0), mk(1, 8'h44, 1)};
    check_q("t4");
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    mon_base = mon_q.size();
    load(0, 2, 1, 8'h60);
    load(1, 2, 1, 8'h70);
    load(2, 2, 1, 8'h80);
    load(3, 2, 1, 8'h90);
    #1;
    chk("t5_rdy", in_tready, 4'b0001);
    repeat (9) tick();
    exp_q = {mk(0, 8'h60, 1), mk(1, 8'h70, 1), mk(2, 8'h80, 1), mk(3, 8'h90, 1),
             mk(0, 8'h61, 1), mk(1, 8'h71, 1), mk(2, 8'h81, 1), mk(3, 8'h91, 1)};
    check_q("t5");
    load(2, 3, 3, 8'hA1);
    tick();
    tick();
    outchk("t6_mid", 1'b1, 8'hA2, 5'd2, 1'b0);
    aresetn = 1'b0;
    #1;
    outchk("t6_async_clr", 1'b0, 8'h00, 5'd0, 1'b0);
    chk("t6_idle_rdy", in_tready, 4'b0100);
    idle(2);
    load(1, 2, 2, 8'hB1);
    load(3, 1, 1, 8'hC1);
    tick();
    aresetn = 1'b1;
    #1;
    chk("t6_rdy", in_tready, 4'b0010);
    mon_base = mon_q.size();
    repeat (4) tick();
    exp_q = {mk(1, 8'hB1, 0), mk(1, 8'hB2, 1), mk(3, 8'hC1, 1)};
    check_q("t6");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
